fft_frame_capture: RTL
======================

Name: fft_frame_capture

Overview:
- Sits directly downstream of the pipelined FFT. Consumes its output stream (one complex result per `i_ce`, `i_sync` marking bin 0) and captures whole frames into a ping-pong buffer.
- Replays each captured frame to a back-pressured consumer over a valid/ready stream with an end-of-frame marker.
- Decouples the FFT's fixed-rate, non-stallable output from a reader that may stall.

Parameters:
- LGSIZE, 11, log2 of frame length (N = 2^LGSIZE = 2048 bins)
- OWIDTH, 21, width of each real/imag component; data word is 2*OWIDTH bits

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous reset, active high
- i_ce  in  1  FFT result strobe; `i_result`/`i_sync` valid when high
- i_sync  in  1  high with bin 0 of each FFT frame
- i_result  in  2*OWIDTH  {real, imag} two's complement result
- o_valid  out  1  output word valid
- i_ready  in  1  consumer accepts word when `o_valid` && `i_ready`
- o_data  out  2*OWIDTH  bin value, bins in order 0..N-1
- o_last  out  1  high with bin N-1
- o_dropped  out  1  sticky: at least one frame discarded (both banks full)
- o_resync  out  1  sticky: `i_sync` arrived mid-frame

Behaviour:
- Reset (sync, active high): `o_valid`=0, `o_last`=0, `o_dropped`=0, `o_resync`=0, both bank-full flags clear, write FSM→IDLE, read counter 0, output skid entries empty. Reset mid-frame abandons all buffered data.
- Write FSM:
  - States: IDLE, FILL, DROP.
  - IDLE→FILL on `i_ce`&&`i_sync` when the target bank is not full; that sample is written at address 0.
  - IDLE→DROP on `i_ce`&&`i_sync` when the target bank is full; set `o_dropped`.
  - FILL: each `i_ce` writes `i_result` at wptr. On the write of wptr=N-1, set full[bank], toggle bank, go to IDLE. The next sample, normally sync, is handled by IDLE in the same cycle rule, so back-to-back frames lose no samples. The implementation therefore evaluates the IDLE sync decision combinationally from the FILL completion cycle+1.
  - FILL, `i_ce`&&`i_sync` with wptr≠0: set `o_resync`; restart at address 0 in the same bank with the current sample. The partial frame is discarded.
  - DROP: ignore samples. On `i_ce`&&`i_sync`, re-evaluate as IDLE.
  - `i_ce` low: no state change, no write.
- Bank-full flags are registered. A read-side free in cycle t is visible to the write FSM in cycle t+1. Simultaneous set of one bank and free of the other is legal.
- Read side:
  - Reads the bank indexed by rbank when full[rbank].
  - RAM read latency is 1 cycle. A 2-entry output skid holds prefetched words, so an always-ready consumer receives 1 word/clock with no bubbles within a frame.
  - Skid behaviour: `o_data`/`o_last` remain stable while `o_valid`&&!`i_ready`.
  - On acceptance of the `o_last` word: clear full[rbank], toggle rbank.
  - Latency: first `o_valid` no later than 3 cycles after full[bank] is set (registered full flag + RAM read + skid register).
  - A frame is never interleaved with another frame, and the reader never reads a bank being written.
- Arithmetic: wptr/rptr are LGSIZE-bit counters that wrap naturally. Data passes through bit-exact, with no scaling.
- Storage: 2*N words of 2*OWIDTH bits. The RAM has a write port on the write side and a registered read port on the read side.

Decomposition:
- Shared package fft_pkg:
  - constants LGSIZE, OWIDTH, N
  - typedef for the complex result word {re, im}
  - write-FSM state enum
- One sub-module: fft_capture_ram, a simple dual-port RAM, 2^(LGSIZE+1) x 2*OWIDTH, with 1-cycle registered read.

Test Plan:
- Single frame, `i_ready`=1: feed N samples with `i_ce`=1 and `i_result`={re=k, im=-k} for k=0..2047, `i_sync` at k=0 → 2048 contiguous `o_valid` words in order 0..2047, `o_last` only on word 2047, first `o_valid` within 3 cycles of the 2048th write, both stickies 0.
- Back-to-back frames, `i_ce` toggling 50%, `i_ready`=1: 4 consecutive frames → all 8192 words out in order, `o_dropped`=0.
- Back-pressure: `i_ready`=0 for the duration of 3 frames → frames 1 and 2 captured, frame 3 dropped with `o_dropped`=1. After `i_ready`=1, exactly 4096 words emerge (frames 1, 2), then frame 4 is captured normally.
- Random `i_ready` (30% low): verify `o_data`/`o_last` hold stable while stalled and no word is duplicated or skipped.
- Mid-frame sync: sync at k=0, then a second sync at k=700 → `o_resync`=1, and the output frame begins with the sample from the second sync.
- Reset at write index 1000 with bank 0 full and half read → `o_valid`=0 next cycle, stickies 0. The next sync-aligned frame is captured and delivered in full.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants, the complex result word and the write-side state encoding
// for the FFT frame capture block.
package fft_pkg;

  localparam int LGSIZE = 11;
  localparam int OWIDTH = 21;
  localparam int N      = 1 << LGSIZE;

  typedef struct packed {
    logic [OWIDTH-1:0] re;
    logic [OWIDTH-1:0] im;
  } cplx_t;

  typedef enum logic [1:0] {
    W_IDLE,
    W_FILL,
    W_DROP
  } wstate_t;

endpackage

// File: rtl/fft_capture_ram.sv
// Simple dual-port frame store: one write port, one registered read port
// (data appears the cycle after i_re).
module fft_capture_ram #(
  parameter int AW = 12,
  parameter int DW = 42
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_re) o_rdata <= r_mem[i_raddr];
  end

endmodule

// File: rtl/fft_frame_capture.sv
// Captures whole FFT output frames into a ping-pong buffer and replays each
// frame in bin order over a valid/ready stream that may stall.
import fft_pkg::*;

module fft_frame_capture #(
  parameter int LGSIZE = fft_pkg::LGSIZE,
  parameter int OWIDTH = fft_pkg::OWIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_ce,
  input  logic                  i_sync,
  input  logic [2*OWIDTH-1:0]   i_result,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [2*OWIDTH-1:0]   o_data,
  output logic                  o_last,
  output logic                  o_dropped,
  output logic                  o_resync
);

  localparam int DW = 2*OWIDTH;
  localparam logic [LGSIZE-1:0] LAST = '1;

  wstate_t           r_wstate;
  logic              r_wbank;
  logic [LGSIZE-1:0] r_wptr;
  logic [1:0]        r_full;
  logic              r_dropped;
  logic              r_resync;

  logic              r_rbank;
  logic [LGSIZE-1:0] r_rptr;
  logic              r_rdone;
  logic              r_pend;
  logic              r_pend_last;
  logic [1:0]        r_cnt;
  logic [DW-1:0]     r_sk_data [0:1];
  logic [1:0]        r_sk_last;

  logic              w_we;
  logic [LGSIZE-1:0] w_waddr_lo;
  logic              w_wdone;
  logic [1:0]        w_set;
  logic [1:0]        w_clr;
  logic              w_pop;
  logic              w_issue;
  logic [DW-1:0]     w_rdata;

  // IDLE and DROP share the sync decision, so a frame completing in FILL
  // hands its very next sample straight to that decision.
  always_comb begin
    w_we       = 1'b0;
    w_waddr_lo = r_wptr;
    w_wdone    = 1'b0;
    case (r_wstate)
      W_FILL: begin
        if (i_ce) begin
          w_we = 1'b1;
          if (i_sync && r_wptr != '0) w_waddr_lo = '0;
          else                        w_wdone    = (r_wptr == LAST);
        end
      end
      default: begin
        if (i_ce && i_sync && !r_full[r_wbank]) begin
          w_we       = 1'b1;
          w_waddr_lo = '0;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wstate  <= W_IDLE;
      r_wbank   <= 1'b0;
      r_wptr    <= '0;
      r_dropped <= 1'b0;
      r_resync  <= 1'b0;
    end else begin
      case (r_wstate)
        W_FILL: begin
          if (i_ce) begin
            if (i_sync && r_wptr != '0) begin
              r_resync <= 1'b1;
              r_wptr   <= LGSIZE'(1);
            end else if (w_wdone) begin
              r_wbank  <= ~r_wbank;
              r_wptr   <= '0;
              r_wstate <= W_IDLE;
            end else begin
              r_wptr <= r_wptr + 1'b1;
            end
          end
        end
        default: begin
          if (i_ce && i_sync) begin
            if (!r_full[r_wbank]) begin
              r_wstate <= W_FILL;
              r_wptr   <= LGSIZE'(1);
            end else begin
              r_wstate  <= W_DROP;
              r_dropped <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  // The two sides never touch the same bank flag in one cycle: the writer
  // only fills an empty bank, the reader only frees a full one.
  assign w_set = w_wdone ? (2'b01 << r_wbank) : 2'b00;
  assign w_clr = (w_pop && r_sk_last[0]) ? (2'b01 << r_rbank) : 2'b00;

  always_ff @(posedge i_clk) begin
    if (i_reset) r_full <= 2'b00;
    else         r_full <= (r_full & ~w_clr) | w_set;
  end

  assign w_pop   = o_valid && i_ready;
  assign w_issue = r_full[r_rbank] && !r_rdone &&
                   ((int'(r_cnt) + int'(r_pend)) < (2 + int'(w_pop)));

  // Reads are issued only while the skid plus the in-flight word still fit.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rbank     <= 1'b0;
      r_rptr      <= '0;
      r_rdone     <= 1'b0;
      r_pend      <= 1'b0;
      r_pend_last <= 1'b0;
      r_cnt       <= 2'd0;
      r_sk_last   <= 2'b00;
    end else begin
      r_pend <= w_issue;
      if (w_issue) begin
        r_pend_last <= (r_rptr == LAST);
        r_rptr      <= r_rptr + 1'b1;
        if (r_rptr == LAST) r_rdone <= 1'b1;
      end
      if (w_pop && r_sk_last[0]) begin
        r_rbank <= ~r_rbank;
        r_rdone <= 1'b0;
      end
      case ({r_pend, w_pop})
        2'b10: begin
          r_sk_data[r_cnt[0]] <= w_rdata;
          r_sk_last[r_cnt[0]] <= r_pend_last;
          r_cnt               <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_sk_data[0] <= r_sk_data[1];
          r_sk_last[0] <= r_sk_last[1];
          r_cnt        <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_sk_data[0] <= w_rdata;
            r_sk_last[0] <= r_pend_last;
          end else begin
            r_sk_data[0] <= r_sk_data[1];
            r_sk_last[0] <= r_sk_last[1];
            r_sk_data[1] <= w_rdata;
            r_sk_last[1] <= r_pend_last;
          end
        end
        default: ;
      endcase
    end
  end

  fft_capture_ram #(
    .AW (LGSIZE+1),
    .DW (DW)
  ) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr ({r_wbank, w_waddr_lo}),
    .i_wdata (i_result),
    .i_re    (w_issue),
    .i_raddr ({r_rbank, r_rptr}),
    .o_rdata (w_rdata)
  );

  assign o_valid   = (r_cnt != 2'd0);
  assign o_data    = r_sk_data[0];
  assign o_last    = o_valid && r_sk_last[0];
  assign o_dropped = r_dropped;
  assign o_resync  = r_resync;

endmodule
